mac_acc_stream: RTL and testbench
=================================

// Module: mac_acc_stream
// PURPOSE
//  Parametrised streaming multiply-accumulate: consumes (a,b,last) beats over a
//  valid/ready channel, accumulates a*b across a packet, emits one result per
//  packet (on the beat with last=1). Pipelined multiplier, signed/unsigned mode
//  and optional saturation. Drop-in datapath block for dot-product/filter kernels.
// PARAMETERS
//  W          32  operand width of in_a / in_b
//  ACC_W      64  accumulator/result width; must be >= 2*W
//  MUL_STAGES 1   multiplier pipeline registers, legal 0..4
//  SIGNED     1   1: two's-complement operands and accumulator; 0: unsigned
//  SATURATE   0   1: clamp accumulator on overflow; 0: wrap modulo 2^ACC_W
//  CNT_W      16  width of beat counter out_cnt
// PORTS
//  clk      in   1      clock, all state on rising edge
//  rst      in   1      synchronous, active-high reset
//  in_a     in   W      operand A
//  in_b     in   W      operand B
//  in_last  in   1      final beat of current packet
//  in_vld   in   1      input beat valid
//  in_rdy   out  1      input beat accepted when in_vld & in_rdy
//  out_acc  out  ACC_W  packet sum of a*b
//  out_cnt  out  CNT_W  number of beats in packet (saturates at 2^CNT_W-1)
//  out_ovf  out  1      sticky: an accumulate of this packet overflowed
//  out_vld  out  1      result valid; holds until out_rdy
//  out_rdy  in   1      downstream ready
// BEHAVIOUR
//  - Reset: out_acc=0, out_cnt=0, out_ovf=0, out_vld=0, all stage valids=0,
//    accumulator=0, beat count=0. A partial packet in flight is discarded.
//  - Global stall: adv = ~out_vld | out_rdy; in_rdy = adv (comb). While adv=0
//    every pipeline register, the accumulator and the count hold.
//  - Stages (each advances only when adv=1): input reg -> MUL_STAGES product
//    regs -> accumulate. Product = 2W-bit a*b (signed per SIGNED), sign- or
//    zero-extended to ACC_W. MUL_STAGES=0: product computed comb from input reg.
//  - Latency: last beat accepted at edge t -> out_vld=1 after edge
//    t+MUL_STAGES+1 (no stall). Throughput 1 beat/cycle when out_rdy=1.
//  - Accumulate edge, valid beat: sum = acc + prod; cnt+1 (saturating).
//    Non-last: acc<=sum. Last: out_acc<=sum, out_cnt<=cnt+1, out_ovf<=ovf
//    (including this beat), out_vld<=1; acc<=0, cnt<=0, ovf<=0.
//  - Overflow: SIGNED: operands same sign, result sign differs; unsigned: carry
//    out. SATURATE=1 clamps to max/min (signed) or 2^ACC_W-1 (unsigned);
//    SATURATE=0 wraps. ovf flag set in both modes.
//  - Output: out_vld cleared on edge where out_rdy=1 unless a new last beat
//    lands the same edge (then stays 1 with new data). Single-beat packet
//    (last on first beat) legal: result = a*b, cnt=1.
//  - Bubbles (in_vld=0) between beats of a packet do not affect the sum.
//  - Data outputs undefined-but-stable while out_vld=0; hold while out_vld&~out_rdy.
// TESTING
//  1 Defaults: beats (3,4),(-2,5),(7,-1,last) -> out_acc=-5, out_cnt=3,
//    out_ovf=0, out_vld 2 cycles after last accepted.
//  2 Back-pressure: out_rdy=0 with result pending -> in_rdy=0, pipeline frozen;
//    release out_rdy -> next packet (1,1,last) yields 1, nothing lost/duplicated.
//  3 Back-to-back single-beat packets at full rate, out_rdy=1: (2,3),(4,5),(6,7)
//    -> results 6,20,42 on consecutive cycles, cnt=1 each.
//  4 Overflow, ACC_W=64,W=32,SIGNED=1: 3 beats (0x7FFFFFFF,0x7FFFFFFF) wrap with
//    SATURATE=0, ovf=1; SATURATE=1 -> out_acc=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
//  5 SIGNED=0: (0xFFFFFFFF,2,last) -> out_acc=0x1_FFFF_FFFE, ovf=0.
//  6 rst asserted mid-packet after 2 beats; then (5,5,last) -> out_acc=25,
//    out_cnt=1; sweep MUL_STAGES 0..4 for latency = MUL_STAGES+1.

Source files
------------

// File: rtl/mac_acc_stream.sv
// Streaming multiply-accumulate: sums a*b over each packet of (a,b,last) beats
// and emits one result per packet through a valid/ready output register.
module mac_acc_stream #(
  parameter int W          = 32,
  parameter int ACC_W      = 64,
  parameter int MUL_STAGES = 1,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_last,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf,
  output logic             out_vld,
  input  logic             out_rdy
);

  localparam int PW = 2 * W;

  // Handshake: a beat transfers on a rising edge with in_vld & in_rdy, a result
  // transfers with out_vld & out_rdy. The whole pipe moves as one (adv); while
  // a result waits for out_rdy every stage, the accumulator and the count hold.
  logic adv;
  assign adv    = ~out_vld | out_rdy;
  assign in_rdy = adv;

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         last_q;
  logic         vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
    end else if (adv) begin
      a_q    <= in_a;
      b_q    <= in_b;
      last_q <= in_last;
      vld_q  <= in_vld;
    end
  end

  // Extending both operands to 2W before multiplying makes the low 2W bits of
  // the product correct for both signed and unsigned operation.
  logic [PW-1:0] a_x;
  logic [PW-1:0] b_x;
  logic [PW-1:0] prod_c;

  always_comb begin
    a_x = {{W{1'b0}}, a_q};
    b_x = {{W{1'b0}}, b_q};
    if (SIGNED != 0) begin
      a_x[PW-1:W] = {W{a_q[W-1]}};
      b_x[PW-1:W] = {W{b_q[W-1]}};
    end
    prod_c = a_x * b_x;
  end

  logic [PW-1:0] m_prod;
  logic          m_vld;
  logic          m_last;

  if (MUL_STAGES == 0) begin : g_comb
    assign m_prod = prod_c;
    assign m_vld  = vld_q;
    assign m_last = last_q;
  end else begin : g_pipe
    logic [PW-1:0]         prod_sr [MUL_STAGES];
    logic [MUL_STAGES-1:0] vld_sr;
    logic [MUL_STAGES-1:0] last_sr;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < MUL_STAGES; i++) prod_sr[i] <= '0;
        vld_sr  <= '0;
        last_sr <= '0;
      end else if (adv) begin
        prod_sr[0] <= prod_c;
        vld_sr[0]  <= vld_q;
        last_sr[0] <= last_q;
        for (int i = 1; i < MUL_STAGES; i++) begin
          prod_sr[i] <= prod_sr[i-1];
          vld_sr[i]  <= vld_sr[i-1];
          last_sr[i] <= last_sr[i-1];
        end
      end
    end

    assign m_prod = prod_sr[MUL_STAGES-1];
    assign m_vld  = vld_sr[MUL_STAGES-1];
    assign m_last = last_sr[MUL_STAGES-1];
  end

  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum_x;
  logic [ACC_W-1:0] sum_sel;
  logic [CNT_W-1:0] cnt_n;
  logic             ovf_now;

  always_comb begin
    prod_ext          = '0;
    prod_ext[PW-1:0]  = m_prod;
    if ((SIGNED != 0) && m_prod[PW-1]) begin
      for (int i = PW; i < ACC_W; i++) prod_ext[i] = 1'b1;
    end
    sum_x = {1'b0, acc_q} + {1'b0, prod_ext};
    if (SIGNED != 0) begin
      ovf_now = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                (sum_x[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      ovf_now = sum_x[ACC_W];
    end
    sum_sel = sum_x[ACC_W-1:0];
    // A signed overflow always goes in the direction of the accumulator's sign.
    if (ovf_now && (SATURATE != 0)) begin
      if (SIGNED != 0) begin
        sum_sel = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        sum_sel = '1;
      end
    end
    cnt_n = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      out_acc <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
      out_vld <= 1'b0;
    end else if (adv) begin
      out_vld <= m_vld & m_last;
      if (m_vld) begin
        if (m_last) begin
          out_acc <= sum_sel;
          out_cnt <= cnt_n;
          out_ovf <= ovf_q | ovf_now;
          acc_q   <= '0;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
        end else begin
          acc_q   <= sum_sel;
          cnt_q   <= cnt_n;
          ovf_q   <= ovf_q | ovf_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_stream.sv
// Bench for mac_acc_stream: several parameter sets share one input stream; a
// per-instance monitor compares every presented result against a queue filled
// by an arithmetic reference model when each packet's last beat is issued.
module tb_mac_acc_stream;

  localparam int NCFG = 7;
  localparam int MS_T [NCFG] = '{1, 1, 1, 0, 2, 3, 4};
  localparam int SG_T [NCFG] = '{1, 1, 0, 1, 1, 0, 1};
  localparam int ST_T [NCFG] = '{0, 1, 0, 0, 1, 1, 0};
  localparam int CN_T [NCFG] = '{16, 16, 3, 16, 16, 16, 16};

  typedef struct {
    logic [63:0] acc;
    logic [15:0] cnt;
    logic        ovf;
    int          t_last;
    bit          timed;
  } exp_t;

  exp_t exp_q [NCFG][$];

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     in_a;
  logic [31:0]     in_b;
  logic            in_last;
  logic            in_vld;
  logic            out_rdy = 1'b1;
  logic [NCFG-1:0] in_rdy;
  logic [NCFG-1:0] out_vld;
  logic [NCFG-1:0] out_ovf;
  logic [63:0]     out_acc [NCFG];
  logic [15:0]     out_cnt [NCFG];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int rdy_mode = 0;
  bit lat_mode = 0;
  logic [31:0] pkt_a[$];
  logic [31:0] pkt_b[$];

  // ---------------- clock / reset / ready generation ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = 1'b0;
      default: out_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input int g, input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL cfg%0d %s got=%h exp=%h (t=%0t)", g, nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model(input int g, input int t);
    logic signed [131:0] acc, av, bv, hi, lo;
    exp_t e;
    bit s;
    int maxc;
    s = (SG_T[g] != 0);
    acc = 0;
    e.ovf = 1'b0;
    if (s) begin
      hi = (132'sd1 <<< 63) - 132'sd1;
      lo = -(132'sd1 <<< 63);
    end else begin
      hi = (132'sd1 <<< 64) - 132'sd1;
      lo = 0;
    end
    foreach (pkt_a[i]) begin
      av = s ? {{100{pkt_a[i][31]}}, pkt_a[i]} : {100'd0, pkt_a[i]};
      bv = s ? {{100{pkt_b[i][31]}}, pkt_b[i]} : {100'd0, pkt_b[i]};
      acc = acc + av * bv;
      if (acc > hi || acc < lo) begin
        e.ovf = 1'b1;
        if (ST_T[g] != 0) acc = (acc > hi) ? hi : lo;
        else acc = s ? {{68{acc[63]}}, acc[63:0]} : {68'd0, acc[63:0]};
      end
    end
    e.acc = acc[63:0];
    maxc = (1 << CN_T[g]) - 1;
    e.cnt = 16'((pkt_a.size() > maxc) ? maxc : pkt_a.size());
    e.t_last = t;
    e.timed = lat_mode;
    return e;
  endfunction

  // ---------------- DUTs and monitors ----------------
  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    logic [CN_T[g]-1:0] cnt_w;
    logic prev_vld = 1'b0;
    logic prev_hs = 1'b0;

    mac_acc_stream #(
      .W(32), .ACC_W(64), .MUL_STAGES(MS_T[g]), .SIGNED(SG_T[g]),
      .SATURATE(ST_T[g]), .CNT_W(CN_T[g])
    ) dut (
      .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .in_vld(in_vld), .in_rdy(in_rdy[g]), .out_acc(out_acc[g]), .out_cnt(cnt_w),
      .out_ovf(out_ovf[g]), .out_vld(out_vld[g]), .out_rdy(out_rdy)
    );

    assign out_cnt[g] = 16'(cnt_w);

    always @(negedge clk) begin
      exp_t e;
      if (rst) begin
        prev_vld = 1'b0;
        prev_hs  = 1'b0;
      end else begin
        if (out_vld[g]) begin
          if (exp_q[g].size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL cfg%0d unexpected_result got acc=%h cnt=%0d, none expected", g, out_acc[g], out_cnt[g]);
          end else begin
            e = exp_q[g][0];
            check(g, "out_acc", out_acc[g], e.acc);
            check(g, "out_cnt", 64'(out_cnt[g]), 64'(e.cnt));
            check(g, "out_ovf", 64'(out_ovf[g]), 64'(e.ovf));
            if ((!prev_vld || prev_hs) && e.timed)
              check(g, "latency", 64'(cyc - e.t_last), 64'(MS_T[g] + 1));
            if (out_rdy) void'(exp_q[g].pop_front());
          end
        end
        prev_vld = out_vld[g];
        prev_hs  = out_vld[g] & out_rdy;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last, input int gap);
    bit done;
    done = 0;
    repeat (gap) begin
      @(negedge clk);
      in_vld = 1'b0;
    end
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (&in_rdy) begin
        in_vld = 1'b1;
        in_a = a;
        in_b = b;
        in_last = last;
        done = 1;
        pkt_a.push_back(a);
        pkt_b.push_back(b);
        if (last) begin
          for (int g = 0; g < NCFG; g++) exp_q[g].push_back(model(g, cyc + 1));
          pkt_a.delete();
          pkt_b.delete();
        end
      end else begin
        in_vld = 1'b0;
      end
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout in_rdy=%b exp=all ones", in_rdy);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_vld = 1'b0;
    end
  endtask

  function automatic bit pending();
    bit p;
    p = 0;
    for (int g = 0; g < NCFG; g++) if (exp_q[g].size() != 0) p = 1;
    return p;
  endfunction

  task automatic drain();
    int k;
    k = 0;
    idle(1);
    while (k < 3000 && pending()) begin
      @(negedge clk);
      k++;
    end
    if (pending()) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout results still outstanding after %0d cycles, exp=0", k);
    end
  endtask

  task automatic set_rdy(input int mode);
    rdy_mode = mode;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 32'($signed($urandom_range(0, 16)) - 8);
      1:       return $urandom;
      2:       return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: return 32'($urandom_range(0, 1000));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int len;
    rst = 1'b1;
    in_vld = 1'b0;
    in_a = '0;
    in_b = '0;
    in_last = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check(g, "rst_out_vld", 64'(out_vld[g]), 64'd0);
      check(g, "rst_out_acc", out_acc[g], 64'd0);
      check(g, "rst_out_cnt", 64'(out_cnt[g]), 64'd0);
      check(g, "rst_out_ovf", 64'(out_ovf[g]), 64'd0);
      check(g, "rst_in_rdy", 64'(in_rdy[g]), 64'd1);
    end
    rst = 1'b0;
    lat_mode = 1;

    // three-beat signed packet: 12 - 10 - 7 = -5
    send(32'd3, 32'd4, 1'b0, 0);
    send(32'hFFFF_FFFE, 32'd5, 1'b0, 0);
    send(32'd7, 32'hFFFF_FFFF, 1'b1, 0);
    idle(8);

    // back-to-back single-beat packets at full rate
    send(32'd2, 32'd3, 1'b1, 0);
    send(32'd4, 32'd5, 1'b1, 0);
    send(32'd6, 32'd7, 1'b1, 0);
    idle(8);

    // overflow of the signed 64-bit accumulator on the third beat
    for (int k = 0; k < 3; k++) send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'(k == 2), 0);
    idle(8);

    // unsigned vs signed interpretation of all-ones
    send(32'hFFFF_FFFF, 32'd2, 1'b1, 0);
    // beat count saturation on the narrow-counter instance, with bubbles
    for (int k = 0; k < 9; k++) send(32'd1, 32'd1, 1'(k == 8), k % 2);
    drain();

    // back-pressure: result held, input refused, then released
    lat_mode = 0;
    set_rdy(1);
    send(32'd10, 32'd10, 1'b1, 0);
    idle(10);
    for (int g = 0; g < NCFG; g++) check(g, "in_rdy_stalled", 64'(in_rdy[g]), 64'd0);
    set_rdy(0);
    send(32'd1, 32'd1, 1'b1, 0);
    drain();

    // random packets, random bubbles, random downstream ready
    set_rdy(2);
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        send(rand_op(), rand_op(), 1'(k == len - 1), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    drain();

    // reset in the middle of a packet discards the partial sum
    set_rdy(0);
    lat_mode = 1;
    send(32'd9, 32'd9, 1'b0, 0);
    send(32'd8, 32'd8, 1'b0, 0);
    @(negedge clk);
    in_vld = 1'b0;
    rst = 1'b1;
    pkt_a.delete();
    pkt_b.delete();
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) check(g, "midrst_out_vld", 64'(out_vld[g]), 64'd0);
    rst = 1'b0;
    send(32'd5, 32'd5, 1'b1, 0);
    drain();

    for (int g = 0; g < NCFG; g++) check(g, "queue_empty", 64'(exp_q[g].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
